sys_bus_timeout: RTL

- Watchdog stage inserted between the system bus master (PS GP-port bridge) and the system bus interconnect.
- Passes every request through unchanged and tracks the single outstanding transaction.
- If no slave acknowledges within TIMEOUT cycles (unmapped or hung slave), it completes the transfer itself with err=1 and a marker read word, so the CPU never stalls.
- Keeps sticky diagnostics (timeout count, last failing address) for a housekeeping register.

---
 rtl/sys_bus_pkg.sv | 38 +++
 rtl/sys_bus_timeout.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sys_bus_pkg.sv
// Shared definitions for the system bus: FSM state encoding, default error
// read word, and the request/response bundles used by bus-side wrappers.
package sys_bus_pkg;

    // Read word returned to the master when an access times out.
    localparam logic [31:0] SYS_BUS_ERR_DATA = 32'hDEAD_BEEF;

    // Transaction tracker states.
    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_WAIT = 1'b1
    } bus_state_e;

    // Plain constants for the state register.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Master-to-slave request bundle.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic        ren;
    } sys_bus_req_t;

    // Slave-to-master response bundle.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        ack;
    } sys_bus_rsp_t;

    // True when the request carries a read or write strobe.
    function automatic logic req_strobe(input sys_bus_req_t req);
        return req.wen | req.ren;
    endfunction

endpackage

// File: rtl/sys_bus_timeout.sv
// Bus watchdog between the bus master and the interconnect. Requests pass
// straight through; one outstanding transaction is tracked and, if no slave
// acknowledges within TIMEOUT cycles, the block completes it itself with an
// error and a marker read word. Sticky diagnostics record how many timeouts
// occurred and the address of the latest one.
module sys_bus_timeout
    import sys_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 256,
    parameter int unsigned TW       = 16,
    parameter logic [31:0] ERR_DATA = SYS_BUS_ERR_DATA
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [31:0]   m_addr,
    input  logic [31:0]   m_wdata,
    input  logic          m_wen,
    input  logic          m_ren,
    output logic [31:0]   m_rdata,
    output logic          m_err,
    output logic          m_ack,
    output logic [31:0]   s_addr,
    output logic [31:0]   s_wdata,
    output logic          s_wen,
    output logic          s_ren,
    input  logic [31:0]   s_rdata,
    input  logic          s_err,
    input  logic          s_ack,
    output logic          busy,
    output logic [TW-1:0] to_cnt,
    output logic [31:0]   to_addr
);

    // Wide enough to hold TIMEOUT-1 without ever wrapping.
    localparam int unsigned     CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    sys_bus_req_t  req_s;
    sys_bus_rsp_t  rsp_s;
    logic          strobe_s;
    logic          fwd_ack_s;
    logic [CW-1:0] cnt_inc_s;

    logic [0:0]    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [31:0]   addr_q,    addr_d;
    logic          force_q,   force_d;
    logic [TW-1:0] to_cnt_q,  to_cnt_d;
    logic [31:0]   to_addr_q, to_addr_d;

    assign req_s    = '{addr: m_addr, wdata: m_wdata, wen: m_wen, ren: m_ren};
    assign strobe_s = req_strobe(req_s);

    // Next-state logic: strobe forwarding, ack forwarding and timeout detection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        force_d   = 1'b0;
        to_cnt_d  = to_cnt_q;
        to_addr_d = to_addr_q;
        s_wen     = 1'b0;
        s_ren     = 1'b0;
        fwd_ack_s = 1'b0;
        cnt_inc_s = cnt_q + CW'(1);
        case (state_q)
            ST_IDLE: begin
                s_wen = req_s.wen;
                s_ren = req_s.ren;
                if (strobe_s) begin
                    if (s_ack) begin
                        fwd_ack_s = 1'b1;
                    end else begin
                        addr_d  = req_s.addr;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end else begin
                    // A stray ack with no strobe is dropped.
                    fwd_ack_s = 1'b0;
                end
            end
            ST_WAIT: begin
                // New strobes here are protocol violations and are not forwarded.
                if (s_ack) begin
                    // Slave ack wins even in the cycle the timeout would fire.
                    fwd_ack_s = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt_inc_s == CNT_LAST) begin
                    force_d   = 1'b1;
                    cnt_d     = '0;
                    to_cnt_d  = (&to_cnt_q) ? to_cnt_q : to_cnt_q + TW'(1);
                    to_addr_d = addr_q;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, latched address, forced-ack and diagnostic registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= 32'h0000_0000;
            force_q   <= 1'b0;
            to_cnt_q  <= '0;
            to_addr_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            force_q   <= force_d;
            to_cnt_q  <= to_cnt_d;
            to_addr_q <= to_addr_d;
        end
    end

    // Response to the master: forced error completion takes priority over a
    // forwarded slave response; everything reads zero when no ack is given.
    always_comb begin
        rsp_s = '0;
        if (force_q) begin
            rsp_s.ack   = 1'b1;
            rsp_s.err   = 1'b1;
            rsp_s.rdata = ERR_DATA;
        end else if (fwd_ack_s) begin
            rsp_s.ack   = 1'b1;
            rsp_s.err   = s_err;
            rsp_s.rdata = s_rdata;
        end else begin
            rsp_s = '0;
        end
    end

    assign m_ack   = rsp_s.ack;
    assign m_err   = rsp_s.err;
    assign m_rdata = rsp_s.rdata;
    assign s_addr  = req_s.addr;
    assign s_wdata = req_s.wdata;
    assign busy    = (state_q == ST_WAIT);
    assign to_cnt  = to_cnt_q;
    assign to_addr = to_addr_q;

endmodule
